snoop_dispatch: RTL



---
 rtl/bpf_pkg.sv | 19 +
 rtl/snoop_dispatch_if.sv | 31 +++
 rtl/snoop_dispatch_rr_pick.sv | 28 ++
 rtl/snoop_dispatch.sv | 98 +++++++++
 4 files changed

// File: rtl/bpf_pkg.sv
// rtl/bpf_pkg.sv - shared bpf widths, VM index width helper and dispatch FSM states
package bpf_pkg;

   localparam int CODE_ADDR_WIDTH        = 10;
   localparam int CODE_DATA_WIDTH        = 64;
   localparam int PACKET_BYTE_ADDR_WIDTH = 12;
   localparam int PACKET_ADDR_WIDTH      = 10;
   localparam int PACKET_DATA_WIDTH      = 32;

   function automatic int vm_idx_width(input int n_vms);
      return (n_vms > 1) ? $clog2(n_vms) : 1;
   endfunction

   typedef enum logic {
      IDLE,
      GRANTED
   } dispatch_state_e;

endpackage

// File: rtl/snoop_dispatch_if.sv
// rtl/snoop_dispatch_if.sv - snooper-side and per-VM bus bundle for snoop_dispatch
interface snoop_dispatch_if #(
   parameter int N_VMS             = 4,
   parameter int PACKET_ADDR_WIDTH = 10,
   parameter int DATA_WIDTH        = 32
);
   localparam int IDX_W = bpf_pkg::vm_idx_width(N_VMS);

   logic [PACKET_ADDR_WIDTH-1:0]       snooper_wr_addr;
   logic [DATA_WIDTH-1:0]              snooper_wr_data;
   logic                               snooper_wr_en;
   logic                               snooper_done;
   logic                               ready_for_snooper;
   logic [N_VMS-1:0]                   vm_ready;
   logic [N_VMS*PACKET_ADDR_WIDTH-1:0] vm_wr_addr;
   logic [N_VMS*DATA_WIDTH-1:0]        vm_wr_data;
   logic [N_VMS-1:0]                   vm_wr_en;
   logic [N_VMS-1:0]                   vm_done;
   logic [IDX_W-1:0]                   grant_idx;

   modport slave (
      input  snooper_wr_addr, snooper_wr_data, snooper_wr_en, snooper_done, vm_ready,
      output ready_for_snooper, vm_wr_addr, vm_wr_data, vm_wr_en, vm_done, grant_idx
   );

   modport master (
      output snooper_wr_addr, snooper_wr_data, snooper_wr_en, snooper_done, vm_ready,
      input  ready_for_snooper, vm_wr_addr, vm_wr_data, vm_wr_en, vm_done, grant_idx
   );

endinterface

// File: rtl/snoop_dispatch_rr_pick.sv
// rtl/snoop_dispatch_rr_pick.sv - combinational round-robin picker, searches from last+1 with wrap
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = bpf_pkg::vm_idx_width(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic          hit,
   output logic [IW-1:0] idx
);

   logic [IW-1:0] cand;

   always_comb begin
      hit  = 1'b0;
      idx  = '0;
      cand = '0;
      // Offset N wraps back to last itself, so a lone requester is always re-picked.
      for (int k = 1; k <= N; k++) begin
         cand = IW'((int'(last) + k) % N);
         if (!hit && req[cand]) begin
            hit = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/snoop_dispatch.sv
// rtl/snoop_dispatch.sv - round-robin share of one snooper stream among N_VMS bpfvm filters
// Optional counters pkt_count/drop_count under SNOOP_DISPATCH_STATS_EN.
module snoop_dispatch
   import bpf_pkg::*;
#(
   parameter int N_VMS             = 4,
   parameter int PACKET_ADDR_WIDTH = 10,
   parameter int DATA_WIDTH        = 32
) (
   input  logic                clk,
   input  logic                rst,
   snoop_dispatch_if.slave     bus
`ifdef SNOOP_DISPATCH_STATS_EN
   ,
   output logic [31:0]         pkt_count,
   output logic [31:0]         drop_count
`endif
);

   localparam int IW = vm_idx_width(N_VMS);

   dispatch_state_e state;
   logic [IW-1:0]   last;
   logic [IW-1:0]   grant;
   logic            pick_hit;
   logic [IW-1:0]   pick_idx;

   rr_pick #(
      .N  (N_VMS),
      .IW (IW)
   ) u_pick (
      .req  (bus.vm_ready),
      .last (last),
      .hit  (pick_hit),
      .idx  (pick_idx)
   );

   assign bus.grant_idx = grant;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state                 <= IDLE;
         last                  <= IW'(N_VMS - 1);
         grant                 <= '0;
         bus.ready_for_snooper <= 1'b0;
         bus.vm_wr_addr        <= '0;
         bus.vm_wr_data        <= '0;
         bus.vm_wr_en          <= '0;
         bus.vm_done           <= '0;
      end else begin
         bus.vm_wr_addr <= '0;
         bus.vm_wr_data <= '0;
         bus.vm_wr_en   <= '0;
         bus.vm_done    <= '0;
         case (state)
            IDLE: begin
               if (pick_hit) begin
                  state                 <= GRANTED;
                  grant                 <= pick_idx;
                  last                  <= pick_idx;
                  bus.ready_for_snooper <= 1'b1;
               end
            end
            GRANTED: begin
               // vm_ready is not looked at here: a packet, once granted, always completes.
               for (int i = 0; i < N_VMS; i++) begin
                  if (IW'(i) == grant) begin
                     bus.vm_wr_addr[i*PACKET_ADDR_WIDTH +: PACKET_ADDR_WIDTH] <= bus.snooper_wr_addr;
                     bus.vm_wr_data[i*DATA_WIDTH +: DATA_WIDTH]               <= bus.snooper_wr_data;
                     bus.vm_wr_en[i]                                          <= bus.snooper_wr_en;
                     bus.vm_done[i]                                           <= bus.snooper_done;
                  end
               end
               if (bus.snooper_done) begin
                  state                 <= IDLE;
                  bus.ready_for_snooper <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef SNOOP_DISPATCH_STATS_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pkt_count  <= '0;
         drop_count <= '0;
      end else begin
         if (state == GRANTED && bus.snooper_done && pkt_count != 32'hFFFF_FFFF)
            pkt_count <= pkt_count + 32'd1;
         if (state == IDLE && (bus.snooper_wr_en || bus.snooper_done) && drop_count != 32'hFFFF_FFFF)
            drop_count <= drop_count + 32'd1;
      end
   end
`endif

endmodule
